// File: rtl/stack_if.sv
// Stack port bundle: operation requests from the datapath and stack status back to it.
interface stack_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
);
  logic              Push;
  logic              Pop;
  logic [WIDTH-1:0]  DataIn;
  logic              ClearErr;
  logic [WIDTH-1:0]  TOS;
  logic [WIDTH-1:0]  NOS;
  logic [ADDR_W:0]   Count;
  logic              Empty;
  logic              Full;
  logic              Overflow;
  logic              Underflow;

  modport master (
    output Push, Pop, DataIn, ClearErr,
    input  TOS, NOS, Count, Empty, Full, Overflow, Underflow
  );

  modport slave (
    input  Push, Pop, DataIn, ClearErr,
    output TOS, NOS, Count, Empty, Full, Overflow, Underflow
  );
endinterface

// File: rtl/stack_engine.sv
// Hardware stack: TOS register over a pointer-addressed array, push/pop/replace in one cycle.
// STACK_GUARD_EN selects guarded boundaries with sticky error flags; undefined gives circular mode.
module stack_engine #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic    CLK,
  input logic    RSTn,
  stack_if.slave bus
);
  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_TWO  = (ADDR_W + 1)'(2);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  tos;
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] wp_prev;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic [WIDTH-1:0]  nos;
  logic              do_replace;
  logic              do_push;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign wp_prev = wp - ADDR_W'(1);
  assign nos     = (count < CNT_TWO) ? '0 : mem[wp_prev];

  // Replace on an empty stack degenerates to a plain push.
  assign do_replace = bus.Push & bus.Pop & ~empty;
  assign do_push    = bus.Push & ~do_replace;
  assign pop_ok     = bus.Pop & ~bus.Push & ~empty;

`ifdef STACK_GUARD_EN
  logic ovf;
  logic udf;

  assign push_ok = do_push & ~full;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= (ovf & ~bus.ClearErr) | (do_push & full);
      udf <= (udf & ~bus.ClearErr) | (bus.Pop & ~bus.Push & empty);
    end
  end
`else
  logic ovf;
  logic udf;
  logic unused_clear_err;

  // A push while full overwrites the oldest entry by letting the pointer wrap.
  assign push_ok          = do_push;
  assign ovf              = 1'b0;
  assign udf              = 1'b0;
  assign unused_clear_err = bus.ClearErr;
`endif

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wp] <= tos;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      tos   <= '0;
      wp    <= '0;
      count <= '0;
    end else if (do_replace) begin
      tos <= bus.DataIn;
    end else if (push_ok) begin
      tos <= bus.DataIn;
      wp  <= wp + ADDR_W'(1);
      if (!full) count <= count + 1'b1;
    end else if (pop_ok) begin
      tos   <= nos;
      wp    <= wp_prev;
      count <= count - 1'b1;
    end
  end

  assign bus.TOS       = tos;
  assign bus.NOS       = nos;
  assign bus.Count     = count;
  assign bus.Empty     = empty;
  assign bus.Full      = full;
  assign bus.Overflow  = ovf;
  assign bus.Underflow = udf;
endmodule

// File: tb/tb_stack_engine.sv
// Scoreboard bench for stack_engine: a queue-based stack model predicts every post-edge state.
module tb_stack_engine;
  localparam int W     = 16;
  localparam int A     = 2;
  localparam int DEPTH = 2 ** A;

  typedef struct {
    logic [W-1:0] tos;
    logic [W-1:0] nos;
    int           count;
    logic         ovf;
    logic         udf;
  } exp_t;

  logic CLK;
  logic RSTn;
  int   checks = 0;
  int   errors = 0;

  stack_if #(.WIDTH(W), .ADDR_W(A)) bus ();

  stack_engine #(.WIDTH(W), .ADDR_W(A)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [W-1:0] mq [$];
  logic         m_ovf;
  logic         m_udf;
  exp_t         exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, req);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic model_step(input bit p, input bit q, input logic [W-1:0] d, input bit c);
    bit ovf_ev = 1'b0;
    bit udf_ev = 1'b0;
    if (p && q && mq.size() > 0) begin
      mq[mq.size()-1] = d;
    end else if (p) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else begin
`ifdef STACK_GUARD_EN
        ovf_ev = 1'b1;
`else
        void'(mq.pop_front());
        mq.push_back(d);
`endif
      end
    end else if (q) begin
      if (mq.size() > 0) void'(mq.pop_back());
      else udf_ev = 1'b1;
    end
`ifdef STACK_GUARD_EN
    m_ovf = (m_ovf && !c) || ovf_ev;
    m_udf = (m_udf && !c) || udf_ev;
`else
    m_ovf = 1'b0;
    m_udf = 1'b0;
`endif
  endtask

  function automatic exp_t model_view();
    exp_t e;
    int   n = mq.size();
    e.tos   = (n > 0) ? mq[n-1] : '0;
    e.nos   = (n > 1) ? mq[n-2] : '0;
    e.count = n;
    e.ovf   = m_ovf;
    e.udf   = m_udf;
    return e;
  endfunction

  task automatic op(input bit p, input bit q, input logic [W-1:0] d, input bit c);
    @(negedge CLK);
    bus.Push     = p;
    bus.Pop      = q;
    bus.DataIn   = d;
    bus.ClearErr = c;
    model_step(p, q, d, c);
    exp_q.push_back(model_view());
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".tos"},   64'(bus.TOS), 64'h0);
    check({tag, ".nos"},   64'(bus.NOS), 64'h0);
    check({tag, ".count"}, 64'(bus.Count), 64'h0);
    check({tag, ".empty"}, 64'(bus.Empty), 64'h1);
    check({tag, ".full"},  64'(bus.Full), 64'h0);
    check({tag, ".ovf"},   64'(bus.Overflow), 64'h0);
    check({tag, ".udf"},   64'(bus.Underflow), 64'h0);
  endtask

  // Monitor: compares the DUT state just after each edge against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("tos",   64'(bus.TOS), 64'(e.tos));
        check("nos",   64'(bus.NOS), 64'(e.nos));
        check("count", 64'(bus.Count), 64'(e.count));
        check("empty", 64'(bus.Empty), 64'(e.count == 0));
        check("full",  64'(bus.Full), 64'(e.count == DEPTH));
        check("ovf",   64'(bus.Overflow), 64'(e.ovf));
        check("udf",   64'(bus.Underflow), 64'(e.udf));
      end
    end
  end

  initial begin
    int mode;
    int wait_cyc;
    RSTn         = 1'b0;
    bus.Push     = 1'b0;
    bus.Pop      = 1'b0;
    bus.DataIn   = '0;
    bus.ClearErr = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    #1 check_reset("reset_release");

    op(0, 0, '0, 0);
    op(1, 0, 16'h1111, 0);
    op(1, 0, 16'h2222, 0);
    op(1, 0, 16'h3333, 0);
    repeat (3) op(0, 1, '0, 0);

    op(1, 0, 16'h0007, 0);
    op(1, 0, 16'h0005, 0);
    op(1, 1, 16'h000C, 0);
    repeat (2) op(0, 1, '0, 0);
    op(1, 1, 16'h00AB, 0);
    op(0, 1, '0, 0);

    for (int i = 1; i <= 5; i++) op(1, 0, 16'(i), 0);
    op(1, 1, 16'h0099, 0);
    op(0, 0, '0, 1);
    repeat (5) op(0, 1, '0, 0);
    op(0, 0, '0, 1);

    for (int i = 1; i <= 6; i++) op(1, 0, 16'(i), 0);
    repeat (5) op(0, 1, '0, 0);

    for (int i = 1; i <= 5; i++) op(1, 0, 16'(16'hA0 + i), 0);
    @(negedge CLK);
    bus.Push   = 1'b1;
    bus.Pop    = 1'b0;
    bus.DataIn = 16'hBEEF;
    #2 RSTn = 1'b0;
    #1 check_reset("mid_push_reset");
    @(posedge CLK);
    #1 check_reset("reset_held_over_edge");
    @(negedge CLK);
    bus.Push = 1'b0;
    model_reset();
    RSTn = 1'b1;
    #1 check_reset("reset_release2");

    for (int i = 0; i < 3000; i++) begin
      bit p, q, c;
      mode = (i / 150) % 3;
      case (mode)
        0:       begin p = ($urandom_range(0, 9) < 7); q = ($urandom_range(0, 9) < 3); end
        1:       begin p = ($urandom_range(0, 9) < 3); q = ($urandom_range(0, 9) < 7); end
        default: begin p = ($urandom_range(0, 1) == 1); q = ($urandom_range(0, 1) == 1); end
      endcase
      c = ($urandom_range(0, 15) == 0);
      op(p, q, W'($urandom), c);
    end
    op(0, 0, '0, 0);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(negedge CLK);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
